bsg_counter_clear_up_down: RTL and testbench

Parametrised up/down counter with a synchronous clear, multi-unit step inputs, and a selectable wrap or saturate policy at a configurable maximum value. It is the generalised successor of the single-increment clear/up counter. It is used for credit tracking, occupancy counts, and event accounting, where one cycle may both add and remove several units. All state is registered on one clock.

---
 rtl/bsg_counter_clear_up_down.sv | 96 +++++++++
 tb/tb_bsg_counter_clear_up_down.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/bsg_counter_clear_up_down.sv
// Up/down counter with synchronous clear, multi-unit steps and a wrap or saturate policy at max_val_p.
// Define BSG_COUNTER_CLEAR_UP_DOWN_STICKY_ERR_EN to get a sticky range-violation flag on err_o.
module bsg_counter_clear_up_down #(
   parameter int max_val_p    = 1000,
   parameter int init_val_p   = 0,
   parameter int step_width_p = 4,
   parameter int saturate_p   = 0,
   parameter int ptr_width_lp = $clog2(max_val_p + 1)
) (
   input  logic                    clk_i,
   input  logic                    reset_n_i,
   input  logic                    clear_i,
   input  logic [step_width_p-1:0] up_i,
   input  logic [step_width_p-1:0] down_i,
   output logic [ptr_width_lp-1:0] count_o,
   output logic                    at_max_o,
   output logic                    at_zero_o,
   output logic                    wrap_o,
   output logic                    err_o
);

   localparam int sum_w_lp = ptr_width_lp + 2;
   localparam logic signed [sum_w_lp-1:0] max_s_lp   = sum_w_lp'(max_val_p);
   localparam logic signed [sum_w_lp-1:0] range_s_lp = sum_w_lp'(max_val_p + 1);

   logic [ptr_width_lp-1:0]    count_r;
   logic                       wrap_r;
   logic signed [sum_w_lp-1:0] base_s;
   logic signed [sum_w_lp-1:0] up_s;
   logic signed [sum_w_lp-1:0] down_s;
   logic signed [sum_w_lp-1:0] sum_s;
   logic signed [sum_w_lp-1:0] rem_s;
   logic signed [sum_w_lp-1:0] next_s;
   logic                       overflow;
   logic                       underflow;
   logic                       violation;

   always_comb begin
      base_s    = clear_i ? '0 : $signed({2'b00, count_r});
      up_s      = $signed({{(sum_w_lp-step_width_p){1'b0}}, up_i});
      down_s    = $signed({{(sum_w_lp-step_width_p){1'b0}}, down_i});
      sum_s     = base_s + up_s - down_s;
      underflow = sum_s[sum_w_lp-1];
      overflow  = !underflow && (sum_s > max_s_lp);
      violation = overflow || underflow;

      // Explicit modulo even for power-of-two ranges; signed remainder keeps the dividend's sign.
      rem_s = sum_s % range_s_lp;
      if (rem_s[sum_w_lp-1])
         rem_s = rem_s + range_s_lp;

      next_s = rem_s;
      if (saturate_p != 0) begin
         if (overflow)
            next_s = max_s_lp;
         else if (underflow)
            next_s = '0;
         else
            next_s = sum_s;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         count_r <= ptr_width_lp'(init_val_p);
         wrap_r  <= 1'b0;
      end else begin
         count_r <= ptr_width_lp'(next_s);
         wrap_r  <= violation;
      end
   end

`ifdef BSG_COUNTER_CLEAR_UP_DOWN_STICKY_ERR_EN
   logic err_r;

   // A violation in the clearing cycle wins over the clear.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i)
         err_r <= 1'b0;
      else if (violation)
         err_r <= 1'b1;
      else if (clear_i)
         err_r <= 1'b0;
   end

   assign err_o = err_r;
`else
   assign err_o = 1'b0;
`endif

   assign count_o   = count_r;
   assign wrap_o    = wrap_r;
   assign at_max_o  = (count_r == ptr_width_lp'(max_val_p));
   assign at_zero_o = (count_r == '0);

endmodule

// File: tb/tb_bsg_counter_clear_up_down.sv
// Scoreboard bench: three counter instances (wrap/init 0, saturate/init 0, wrap/init 7) share stimulus
// and are compared each cycle against a behavioural model.
module tb_bsg_counter_clear_up_down;

   localparam int n_dut_lp = 3;
   localparam int max_lp   = 9;

   typedef struct {
      int dut;
      int cnt;
      bit amax;
      bit azero;
      bit wrap;
      bit err;
   } exp_t;

   logic       clk_i = 1'b0;
   logic       reset_n_i;
   logic       clear_i;
   logic [3:0] up_i;
   logic [3:0] down_i;
   logic [3:0] count_o   [n_dut_lp];
   logic       at_max_o  [n_dut_lp];
   logic       at_zero_o [n_dut_lp];
   logic       wrap_o    [n_dut_lp];
   logic       err_o     [n_dut_lp];

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb_q[$];

   int m_cnt  [n_dut_lp];
   bit m_err  [n_dut_lp];
   int m_sat  [n_dut_lp] = '{0, 1, 0};
   int m_init [n_dut_lp] = '{0, 0, 7};

   always #5 clk_i = ~clk_i;

   bsg_counter_clear_up_down #(.max_val_p(9), .init_val_p(0), .step_width_p(4), .saturate_p(0)) u_wrap (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .clear_i(clear_i), .up_i(up_i), .down_i(down_i),
      .count_o(count_o[0]), .at_max_o(at_max_o[0]), .at_zero_o(at_zero_o[0]),
      .wrap_o(wrap_o[0]), .err_o(err_o[0]));

   bsg_counter_clear_up_down #(.max_val_p(9), .init_val_p(0), .step_width_p(4), .saturate_p(1)) u_sat (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .clear_i(clear_i), .up_i(up_i), .down_i(down_i),
      .count_o(count_o[1]), .at_max_o(at_max_o[1]), .at_zero_o(at_zero_o[1]),
      .wrap_o(wrap_o[1]), .err_o(err_o[1]));

   bsg_counter_clear_up_down #(.max_val_p(9), .init_val_p(7), .step_width_p(4), .saturate_p(0)) u_init7 (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .clear_i(clear_i), .up_i(up_i), .down_i(down_i),
      .count_o(count_o[2]), .at_max_o(at_max_o[2]), .at_zero_o(at_zero_o[2]),
      .wrap_o(wrap_o[2]), .err_o(err_o[2]));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Model one update for every instance and queue the expected outputs.
   task automatic push_expected(input bit rst, input bit clr, input int up, input int dn);
      for (int d = 0; d < n_dut_lp; d++) begin
         exp_t e;
         int   s;
         bit   viol;
         viol = 1'b0;
         if (rst) begin
            m_cnt[d] = m_init[d];
            m_err[d] = 1'b0;
         end else begin
            s = (clr ? 0 : m_cnt[d]) + up - dn;
            if (s > max_lp || s < 0) viol = 1'b1;
            if (m_sat[d] != 0) begin
               if (s > max_lp) s = max_lp;
               if (s < 0) s = 0;
            end else begin
               while (s > max_lp) s = s - (max_lp + 1);
               while (s < 0) s = s + (max_lp + 1);
            end
            m_cnt[d] = s;
`ifdef BSG_COUNTER_CLEAR_UP_DOWN_STICKY_ERR_EN
            if (viol) m_err[d] = 1'b1;
            else if (clr) m_err[d] = 1'b0;
`else
            m_err[d] = 1'b0;
`endif
         end
         e.dut   = d;
         e.cnt   = m_cnt[d];
         e.amax  = (m_cnt[d] == max_lp);
         e.azero = (m_cnt[d] == 0);
         e.wrap  = viol;
         e.err   = m_err[d];
         sb_q.push_back(e);
      end
   endtask

   task automatic cyc(input bit rst_n, input bit clr, input int up, input int dn);
      reset_n_i = rst_n;
      clear_i   = clr;
      up_i      = 4'(up);
      down_i    = 4'(dn);
      push_expected(!rst_n, clr, up, dn);
      @(posedge clk_i);
      #1;
      for (int d = 0; d < n_dut_lp; d++) begin
         exp_t e;
         string tg;
         if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
         end else begin
            e  = sb_q.pop_front();
            tg = $sformatf("dut%0d", e.dut);
            check({tg, "_count"},   32'(count_o[e.dut]),   32'(e.cnt));
            check({tg, "_at_max"},  32'(at_max_o[e.dut]),  32'(e.amax));
            check({tg, "_at_zero"}, 32'(at_zero_o[e.dut]), 32'(e.azero));
            check({tg, "_wrap"},    32'(wrap_o[e.dut]),    32'(e.wrap));
            check({tg, "_err"},     32'(err_o[e.dut]),     32'(e.err));
         end
      end
   endtask

   initial begin
      reset_n_i = 1'b0;
      clear_i   = 1'b0;
      up_i      = '0;
      down_i    = '0;
      for (int d = 0; d < n_dut_lp; d++) begin
         m_cnt[d] = m_init[d];
         m_err[d] = 1'b0;
      end
      #2;

      // Reset dominates a pending step.
      cyc(0, 0, 3, 0);
      cyc(0, 0, 3, 0);

      // Approach and cross the top boundary, then idle.
      cyc(1, 0, 8, 0);
      cyc(1, 0, 3, 0);
      cyc(1, 0, 0, 0);
      // Large down step across zero.
      cyc(1, 0, 0, 15);
      cyc(1, 0, 0, 0);

      // Clear does not suppress steps.
      cyc(1, 1, 5, 0);
      cyc(1, 1, 2, 0);
      cyc(1, 1, 0, 1);
      for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0);
      cyc(1, 1, 0, 0);
      cyc(1, 0, 0, 1);
      cyc(1, 1, 0, 1);
      cyc(1, 1, 0, 0);
      cyc(1, 0, 0, 0);

      // Equal up/down holds the count.
      cyc(1, 1, 4, 0);
      cyc(1, 0, 6, 6);
      cyc(1, 0, 15, 15);
      cyc(0, 0, 15, 0);
      cyc(1, 0, 9, 0);
      cyc(1, 0, 1, 0);

      for (int i = 0; i < 300; i++) begin
         cyc(($urandom_range(0, 29) != 0), ($urandom_range(0, 7) == 0),
             int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
